// File: rtl/led_pulse_receiver.sv
// Blue-LED duration-code receiver: measures high pulses in units, decodes them to letter codes,
// and emits symbols and end-of-word markers through a single-entry valid/ready register.
module led_pulse_receiver #(
    parameter int unsigned CLKS_PER_UNIT = 50000000,
    parameter int unsigned WORD_GAP      = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       led_in,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [4:0] sym_code,
    output logic       sym_err,
    output logic       word_end,
    output logic       overrun
);

    localparam int unsigned PW = $clog2(CLKS_PER_UNIT);
    localparam int unsigned GW = $clog2(WORD_GAP + 1);
    localparam int unsigned CW = 5;

    localparam logic [PW-1:0] HALF_M1  = PW'(CLKS_PER_UNIT / 2 - 1);
    localparam logic [PW-1:0] FULL_M1  = PW'(CLKS_PER_UNIT - 1);
    localparam logic [GW-1:0] GAP_END  = GW'(WORD_GAP);
    localparam logic [CW-1:0] CODE_MAX = CW'(31);
    localparam logic [CW-1:0] CODE_LIM = CW'(26);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic          r_sync1;
    logic          r_led_s;
    logic          r_led_d;
    logic [1:0]    r_arm;
    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [CW-1:0] r_units;
    logic [GW-1:0] r_gap;
    logic          r_emit;
    logic [CW-1:0] r_emit_code;
    logic          r_emit_err;
    logic          r_emit_wend;
    logic          r_sym_valid;
    logic [CW-1:0] r_sym_code;
    logic          r_sym_err;
    logic          r_word_end;
    logic          r_overrun;

    logic          w_rise;
    logic          w_fall;
    state_t        w_state_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [CW-1:0] w_units_nxt;
    logic [GW-1:0] w_gap_nxt;
    logic [GW-1:0] w_gap_inc;
    logic          w_emit;
    logic [CW-1:0] w_emit_code;
    logic          w_emit_err;
    logic          w_emit_wend;

    // led_d is held high until the sync chain carries real samples, so a line lit at release makes no edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_led_s <= 1'b0;
            r_led_d <= 1'b1;
            r_arm   <= 2'b00;
        end else begin
            r_sync1 <= led_in;
            r_led_s <= r_sync1;
            r_arm   <= {r_arm[0], 1'b1};
            r_led_d <= r_arm[1] ? r_led_s : 1'b1;
        end
    end

    assign w_rise    = r_led_s & ~r_led_d;
    assign w_fall    = ~r_led_s & r_led_d;
    assign w_gap_inc = r_gap + GW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_units <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_units <= w_units_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // Units tick at mid-unit so the count rounds to the nearest unit; the fall cycle still counts
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_units_nxt = r_units;
        w_gap_nxt   = r_gap;
        w_emit      = 1'b0;
        w_emit_code = '0;
        w_emit_err  = 1'b0;
        w_emit_wend = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_HIGH;
                    w_presc_nxt = '0;
                    w_units_nxt = '0;
                end
            end
            S_HIGH: begin
                w_presc_nxt = (r_presc == FULL_M1) ? '0 : r_presc + PW'(1);
                if ((r_presc == HALF_M1) && (r_units != CODE_MAX)) begin
                    w_units_nxt = r_units + CW'(1);
                end
                if (w_fall) begin
                    w_state_nxt = S_GAP;
                    w_emit      = 1'b1;
                    w_emit_code = w_units_nxt;
                    w_emit_err  = (w_units_nxt == '0) || (w_units_nxt > CODE_LIM);
                    w_presc_nxt = '0;
                    w_gap_nxt   = '0;
                end
            end
            S_GAP: begin
                if (w_rise) begin
                    w_state_nxt = S_HIGH;
                    w_presc_nxt = '0;
                    w_units_nxt = '0;
                end else if (r_presc == FULL_M1) begin
                    w_presc_nxt = '0;
                    if (w_gap_inc == GAP_END) begin
                        w_state_nxt = S_IDLE;
                        w_gap_nxt   = '0;
                        w_emit      = 1'b1;
                        w_emit_wend = 1'b1;
                    end else begin
                        w_gap_nxt = w_gap_inc;
                    end
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One-cycle emit stage ahead of the output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_emit      <= 1'b0;
            r_emit_code <= '0;
            r_emit_err  <= 1'b0;
            r_emit_wend <= 1'b0;
        end else begin
            r_emit      <= w_emit;
            r_emit_code <= w_emit_code;
            r_emit_err  <= w_emit_err;
            r_emit_wend <= w_emit_wend;
        end
    end

    // Single-entry output register; an emit into a stalled entry is dropped and flagged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sym_valid <= 1'b0;
            r_sym_code  <= '0;
            r_sym_err   <= 1'b0;
            r_word_end  <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (r_emit) begin
            if (!r_sym_valid || sym_ready) begin
                r_sym_valid <= 1'b1;
                r_sym_code  <= r_emit_code;
                r_sym_err   <= r_emit_err;
                r_word_end  <= r_emit_wend;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_sym_valid && sym_ready) begin
            r_sym_valid <= 1'b0;
        end
    end

    assign sym_valid = r_sym_valid;
    assign sym_code  = r_sym_code;
    assign sym_err   = r_sym_err;
    assign word_end  = r_word_end;
    assign overrun   = r_overrun;

endmodule

// File: doc/led_pulse_receiver.md
Name: led_pulse_receiver

Overview:
- Receive end of the blue-LED duration code: measures each high pulse on a sensed LED line in time units (1 unit = CLKS_PER_UNIT clocks) and decodes its length into a letter code (1..26 = alphabet index).
- Emits symbols and end-of-word markers through a single-entry valid/ready output register.
- Sits between the photodetector/LED sense input and the character-consuming logic.

Parameters:
- CLKS_PER_UNIT, 50000000, clocks per duration unit. Must be even and at least 2.
- WORD_GAP, 30, number of full low units after a symbol that signals end of word. Must be at least 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- led_in  in  1  asynchronous LED sense input, high = lit
- sym_valid  out  1  output register holds an undelivered entry
- sym_ready  in  1  consumer accepts the entry when high together with sym_valid
- sym_code  out  5  decoded unit count, saturated at 31; 0 for a word-end entry
- sym_err  out  1  entry is an invalid pulse (units = 0 or units > 26)
- word_end  out  1  entry is an end-of-word marker
- overrun  out  1  sticky flag: an entry was dropped

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: all outputs 0; state IDLE; all counters 0.
- Synchronizer: two flops give led_s; a delay flop gives led_d. The sync flops reset to 0 and led_d resets to 1, so a line already high at reset release produces no rising edge. That pulse is ignored.
- Edges: rise = led_s & ~led_d; fall = ~led_s & led_d.
- States:
  - IDLE: line low, no symbol since the last word end. rise -> HIGH.
  - HIGH: measuring a pulse. fall -> GAP and emit a symbol.
  - GAP: measuring low time. rise -> HIGH. When gap units reach WORD_GAP: emit a word-end entry and go to IDLE.
- Pulse measurement (rounds to the nearest unit):
  - On rise: prescaler = 0, units = 0.
  - Each cycle in HIGH, the prescaler counts 0..CLKS_PER_UNIT-1 and wraps.
  - units increments (saturating at 31) on each cycle where prescaler == CLKS_PER_UNIT/2-1.
  - For H high cycles: units = 0 if H < CLKS_PER_UNIT/2, otherwise floor((H - CLKS_PER_UNIT/2)/CLKS_PER_UNIT) + 1.
- Symbol entry: sym_code = units, sym_err = (units==0 or units>26), word_end = 0.
- Gap measurement:
  - On fall: prescaler = 0, gap = 0.
  - gap increments after each full CLKS_PER_UNIT low cycles.
  - The word-end entry has sym_code = 0, sym_err = 0, word_end = 1, and is emitted exactly once per gap.
- Latency: sym_valid rises on the 3rd rising clk edge after the edge that first samples led_in low. The word end follows the same pipeline offset.
- Output register:
  - Loads on emit if sym_valid = 0, or if sym_valid & sym_ready in the same cycle (accept and replace, no overrun).
  - Emit while sym_valid & ~sym_ready: the new entry is dropped, the held entry is unchanged, and overrun is set.
  - Accept without emit clears sym_valid.
  - sym_code, sym_err and word_end stay stable while sym_valid & ~sym_ready.
- overrun clears only on reset.
- Reset mid-pulse or mid-gap: the measurement is discarded and nothing is emitted. A held undelivered entry is lost.
- No glitch filtering beyond the synchronizer. A sub-half-unit pulse yields an error entry, never silence.

Test Plan:
All scenarios use CLKS_PER_UNIT=8 and WORD_GAP=4.
- Reset applied with led_in=0 -> all outputs 0. led_in held high through reset release, then low -> no entry emitted.
- led_in high 40 cycles, sym_ready=1 -> one entry: sym_code=5, sym_err=0, word_end=0. sym_valid rises on the 3rd edge after led_in is sampled low and stays high 1 cycle.
- Pulses of 8, 16 and 112 cycles separated by 16-cycle gaps, then 40 low cycles -> codes 1, 2, 14 in order, then a single entry with word_end=1 and code 0. No second word end during further low time.
- Pulse of 3 cycles -> sym_code=0, sym_err=1. Pulse of 216 cycles -> sym_code=27, sym_err=1. Pulse of 4 cycles -> sym_code=1, sym_err=0 (rounding boundary).
- sym_ready=0 with pulses of 40 then 16 cycles -> held entry stays code 5, overrun=1. Raising sym_ready for 1 cycle -> sym_valid drops and overrun stays 1.
- reset asserted at cycle 20 of a 40-cycle pulse and released before the fall -> no entry emitted, outputs 0. The next 16-cycle pulse decodes to code 2.
